// File: rtl/sad.sv
// Sum of absolute differences over a fixed 256-pair frame.
// The frame starts on enb_i in IDLE and publishes the result on dt_o at LOAD.
module sad (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        enb_i,
  input  logic [7:0]  dta_i,
  input  logic [7:0]  dtb_i,
  output logic        busy_o,
  output logic [31:0] dt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_ACC   = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] sum_q;
  logic [8:0]  i_q;
  logic [31:0] dt_q;

  logic [8:0]  a_ext;
  logic [8:0]  b_ext;
  logic [8:0]  absdiff;
  logic [31:0] sum_d;

  // Larger minus smaller at 9 bits, so the difference never wraps.
  always_comb begin
    a_ext   = {1'b0, dta_i};
    b_ext   = {1'b0, dtb_i};
    absdiff = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
    sum_d   = sum_q + {23'd0, absdiff};
  end

  always_ff @(posedge clk) begin
    if (rstn_i) begin
      state_q <= S_IDLE;
      sum_q   <= 32'd0;
      i_q     <= 9'd0;
      dt_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enb_i) state_q <= S_INIT;
        end
        S_INIT: begin
          sum_q   <= 32'd0;
          i_q     <= 9'd0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          // i_q reaches 256 exactly when bit 8 sets.
          if (i_q[8]) state_q <= S_LOAD;
          else        state_q <= S_ACC;
        end
        S_ACC: begin
          sum_q   <= sum_d;
          i_q     <= i_q + 9'd1;
          state_q <= S_CHECK;
        end
        S_LOAD: begin
          dt_q    <= sum_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign dt_o   = dt_q;

endmodule

// File: tb/tb_sad.sv
// Directed bench for sad: fixed patterns with hand-computed frame sums,
// frame timing, busy width, back-to-back spacing and mid-frame reset.
module tb_sad;

  logic        clk;
  logic        rstn_i;
  logic        enb_i;
  logic [7:0]  dta_i;
  logic [7:0]  dtb_i;
  logic        busy_o;
  logic [31:0] dt_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_dt = 32'd0;
  int          cyc      = 0;
  int          chg_cyc  = 0;
  int          prev_chg = 0;
  bit          chk_gap  = 0;
  logic [31:0] dt_seen  = 32'd0;

  sad dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .enb_i  (enb_i),
    .dta_i  (dta_i),
    .dtb_i  (dtb_i),
    .busy_o (busy_o),
    .dt_o   (dt_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Records the cycle of every dt_o change; in a back-to-back run the gap must be 516.
  always @(negedge clk) begin
    if (dt_o !== dt_seen) begin
      dt_seen  = dt_o;
      prev_chg = chg_cyc;
      chg_cyc  = cyc;
      if (chk_gap) begin
        total++;
        assert (chg_cyc - prev_chg === 516) else begin
          bad++;
          $error("FAIL dt_gap got=%0d exp=516", chg_cyc - prev_chg);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_rand();
    dta_i = 8'($urandom_range(0, 255));
    dtb_i = 8'($urandom_range(0, 255));
  endtask

  // mode 0: a=b=k, mode 1: a=k b=m, mode 2: a=255 b=0
  task automatic drive_pair(input int mode, input int k, input int m);
    case (mode)
      0:       begin dta_i = 8'(k);   dtb_i = 8'(k); end
      1:       begin dta_i = 8'(k);   dtb_i = 8'(m); end
      default: begin dta_i = 8'd255;  dtb_i = 8'd0;  end
    endcase
  endtask

  // Called just after a posedge with the DUT in IDLE; the next posedge is IDLE->INIT (edge 0).
  // Pair k is presented only for edge 3+2k; every other edge sees random data and random enb_i.
  task automatic run_frame(input string tag, input int mode, input int m,
                           input logic [31:0] exp, input bit keep, input int abort_k);
    int busy_cnt;
    bit stable;
    int k;
    busy_cnt = 0;
    stable   = 1'b1;
    @(negedge clk);
    enb_i = 1'b1;
    drive_rand();
    for (int n = 0; n <= 515; n++) begin
      if (n > 0) begin
        @(negedge clk);
        enb_i = keep ? 1'b1 : 1'($urandom_range(0, 1));
        if (n >= 3 && (n % 2) == 1) begin
          k = (n - 3) / 2;
          if (k == abort_k) begin
            rstn_i = 1'b1;
            @(posedge clk); #1;
            check({tag, "_abort_dt"},   dt_o,          32'd0);
            check({tag, "_abort_busy"}, {31'd0, busy_o}, 32'd0);
            model_dt = 32'd0;
            @(negedge clk);
            rstn_i = 1'b0;
            enb_i  = 1'b0;
            return;
          end
          drive_pair(mode, k, m);
        end else begin
          drive_rand();
        end
      end
      @(posedge clk); #1;
      if (n < 515) begin
        if (busy_o === 1'b1) busy_cnt++;
        if (dt_o !== model_dt) stable = 1'b0;
      end
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt),    32'd515);
    check({tag, "_dt_hold"},     {31'd0, stable},  32'd1);
    check({tag, "_dt"},          dt_o,             exp);
    check({tag, "_idle_busy"},   {31'd0, busy_o},  32'd0);
    model_dt = exp;
    if (!keep) enb_i = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_rand();
      @(posedge clk); #1;
      check(tag, {31'd0, busy_o}, 32'd0);
    end
  endtask

  initial begin
    rstn_i = 1'b1;
    enb_i  = 1'b0;
    dta_i  = 8'd0;
    dtb_i  = 8'd0;

    // Reset held for two edges, then released with enb_i low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_dt",   dt_o,            32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rstn_i = 1'b0;
    idle_cycles("idle_busy", 4);
    check("idle_dt", dt_o, 32'd0);

    run_frame("ident",  0, 0,   32'd0,     1'b0, -1);
    idle_cycles("gap1_busy", 2);
    run_frame("m0",     1, 0,   32'd32640, 1'b0, -1);
    idle_cycles("gap2_busy", 2);
    // sum|n-128| over n=0..255 = (128+...+1) + (0+...+127) = 8256 + 8128
    run_frame("m128",   1, 128, 32'd16384, 1'b0, -1);
    idle_cycles("gap3_busy", 2);
    run_frame("m255",   1, 255, 32'd32640, 1'b0, -1);
    idle_cycles("gap4_busy", 2);
    run_frame("max",    2, 0,   32'd65280, 1'b0, -1);
    idle_cycles("gap5_busy", 2);

    // Reset at pair 100 aborts the frame and clears the previous result.
    run_frame("abort",  0, 0,   32'd0,     1'b0, 100);
    idle_cycles("post_abort_busy", 3);
    check("post_abort_dt", dt_o, 32'd0);
    run_frame("after_abort", 1, 255, 32'd32640, 1'b0, -1);
    idle_cycles("gap6_busy", 2);

    // Back-to-back frames with enb_i held high throughout.
    run_frame("b2b_max",   2, 0,   32'd65280, 1'b1, -1);
    run_frame("b2b_m0",    1, 0,   32'd32640, 1'b1, -1);
    chk_gap = 1'b1;
    run_frame("b2b_ident", 0, 0,   32'd0,     1'b1, -1);
    run_frame("b2b_m128",  1, 128, 32'd16384, 1'b0, -1);
    idle_cycles("tail_busy", 3);
    chk_gap = 1'b0;
    check("tail_dt", dt_o, 32'd16384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
